pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Programmable pulse-train controller for the timing core. It owns a 16-bit phase counter and sequences it through start-delay, pulse-high and pulse-low phases, repeating for a configured number of pulses or continuously. It sits between the software-facing configuration registers and the trigger outputs, replacing ad-hoc enable-gated counters wherever a timed pulse train is needed.

## Interface
- CNT_W, 16, width of phase counter and of delay/high/low configuration fields
- REP_W, 8, width of repeat count and completed-pulse counter
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  start request, sampled only in IDLE
- abort_i  input  1  stop request, sampled in every state
- delay_i  input  CNT_W  cycles before first pulse (0 = none)
- high_i  input  CNT_W  pulse-high length in cycles (0 treated as 1)
- low_i  input  CNT_W  pulse-low length in cycles (0 treated as 1)
- repeat_i  input  REP_W  pulses per run (0 = continuous until abort)
- pulse_o  output  1  registered pulse output
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle strobe on normal completion
- cnt_o  output  CNT_W  current phase counter value
- pulses_o  output  REP_W  pulses completed in current/last run

## Operation
- States: IDLE, DELAY, HIGH, LOW. pulse_o = registered (state == HIGH); busy_o = (state != IDLE).
- Config (delay_i, high_i, low_i, repeat_i) latched on the edge that accepts start; changes during a run have no effect.
- IDLE: start_i=1 and abort_i=0 -> DELAY if delay>0 else HIGH; cnt and pulses_o cleared to 0. start_i ignored outside IDLE.
- Phase counter: increments by 1 each cycle in DELAY/HIGH/LOW; on the cycle where cnt == len-1 the state advances and cnt returns to 0. len = delay, max(high,1), max(low,1) respectively.
- DELAY -> HIGH at end of delay.
- HIGH -> LOW at end of high; pulses_o increments on the same edge.
- LOW end: repeat != 0 and pulses_o == repeat -> IDLE with done_o=1 for one cycle; otherwise -> HIGH.
- Continuous mode (repeat=0): pulses_o wraps 255 -> 0, no done_o.
- abort_i=1 in any non-IDLE state: next edge -> IDLE, pulse_o=0, cnt=0, pulses_o held, done_o not asserted. Abort has priority over start and over all phase transitions.
- Arithmetic unsigned; cnt never exceeds len-1; no overflow since len <= 2^CNT_W.
- In IDLE cnt_o holds 0.

## Timing
- Reset values: state IDLE, pulse_o=0, busy_o=0, done_o=0, cnt_o=0, pulses_o=0, latched config 0. Reset mid-run returns all of these immediately, independent of clk_i.
- start accepted at edge k: busy_o high from edge k; pulse_o high from edge k+delay.
- Pulse n (n=0..) rises at edge k+delay+n*(H+L), falls at edge k+delay+n*(H+L)+H, with H=max(high,1), L=max(low,1).
- Normal completion with repeat=R: at edge k+delay+R*(H+L), busy_o falls and done_o rises for exactly one cycle; a start_i sampled on that same edge is ignored (state was LOW); earliest restart on the next edge.
- abort at edge a: pulse_o and busy_o low from edge a.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst_i mid-HIGH with delay=3, high=4 -> pulse_o, busy_o, cnt_o, pulses_o all 0 immediately; no pulse after release without start.
- Basic train: delay=2, high=3, low=5, repeat=2, start at edge 0 -> pulse_o high edges 2-5 and 10-13 (rises 2,10; falls 5,13), done_o single cycle after edge 18, pulses_o=2.
- Zero fields: delay=0, high=0, low=0, repeat=3 -> pulse_o rises at edge k, toggles every cycle, 3 pulses, done_o after edge k+6.
- Continuous + abort: repeat=0, high=1, low=1, run 600 cycles -> pulses_o wraps 255->0; abort_i in HIGH -> pulse_o low next edge, no done_o, pulses_o held.
- Collisions: start with abort in IDLE -> stays IDLE; start_i during run and on completion edge -> ignored; config changed mid-run -> timing unchanged.
- Restart: start on the edge after done_o with new config -> pulses_o cleared, new timing applied.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Programmable pulse-train controller: optional start delay, then HIGH/LOW phases
// repeated for a latched pulse count or continuously until abort.
module pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic [CNT_W-1:0] low_i,
  input  logic [REP_W-1:0] repeat_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [REP_W-1:0] pulses_o
);

  // state   | meaning
  // S_IDLE  | waiting for start, counter parked at 0
  // S_DELAY | counting the start delay
  // S_HIGH  | pulse output high
  // S_LOW   | pulse output low, decides repeat or finish at its end
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] pulses_q, pulses_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] delay_last;
  logic [CNT_W-1:0] high_last;
  logic [CNT_W-1:0] low_last;
  logic [CNT_W-1:0] cnt_inc;

  // Terminal counts; zero-length high/low phases behave as one cycle.
  always_comb begin
    delay_last = delay_q - CNT_W'(1);
    high_last  = (high_q == '0) ? '0 : (high_q - CNT_W'(1));
    low_last   = (low_q == '0) ? '0 : (low_q - CNT_W'(1));
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    high_d   = high_q;
    low_d    = low_q;
    rep_d    = rep_q;
    pulses_d = pulses_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i && !abort_i) begin
          delay_d  = delay_i;
          high_d   = high_i;
          low_d    = low_i;
          rep_d    = repeat_i;
          pulses_d = '0;
          state_d  = (delay_i != '0) ? S_DELAY : S_HIGH;
        end
      end
      S_DELAY: begin
        if (cnt_q == delay_last) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HIGH: begin
        if (cnt_q == high_last) begin
          cnt_d    = '0;
          pulses_d = pulses_q + REP_W'(1);
          state_d  = S_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOW: begin
        if (cnt_q == low_last) begin
          cnt_d = '0;
          if ((rep_q != '0) && (pulses_q == rep_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides every phase transition and keeps the pulse tally.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      pulses_d = pulses_q;
      done_d   = 1'b0;
    end

    pulse_d = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      delay_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      rep_q    <= '0;
      pulses_q <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      high_q   <= high_d;
      low_q    <= low_d;
      rep_q    <= rep_d;
      pulses_q <= pulses_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign cnt_o    = cnt_q;
  assign pulses_o = pulses_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer; edge numbers are counted from the edge that accepts start.
module tb_pulse_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        abort_i;
  logic [15:0] delay_i;
  logic [15:0] high_i;
  logic [15:0] low_i;
  logic [7:0]  repeat_i;
  logic        pulse_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] cnt_o;
  logic [7:0]  pulses_o;

  int errors = 0;
  int checks = 0;

  pulse_sequencer #(.CNT_W(16), .REP_W(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .delay_i  (delay_i),
    .high_i   (high_i),
    .low_i    (low_i),
    .repeat_i (repeat_i),
    .pulse_o  (pulse_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .cnt_o    (cnt_o),
    .pulses_o (pulses_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int d, input int h, input int l, input int r);
    delay_i  = 16'(d);
    high_i   = 16'(h);
    low_i    = 16'(l);
    repeat_i = 8'(r);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    set_cfg(0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({pulse_o, busy_o, done_o, cnt_o, pulses_o} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got p=%b b=%b d=%b cnt=%0d pulses=%0d, want all 0",
               pulse_o, busy_o, done_o, cnt_o, pulses_o);
    end
    rst_i = 1'b0;
    tick();
    set_cfg(3, 4, 2, 1);
    start_i = 1'b1;
    tick();                      // edge 0
    start_i = 1'b0;
    repeat (4) tick();           // edge 4: HIGH, cnt 1
    checks++;
    if (pulse_o !== 1'b1 || cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL reset_prerun: got p=%b cnt=%0d, want p=1 cnt=1", pulse_o, cnt_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({pulse_o, busy_o, done_o, cnt_o, pulses_o} !== 27'd0) begin
      errors++;
      $display("FAIL reset_async: got p=%b b=%b d=%b cnt=%0d pulses=%0d, want all 0",
               pulse_o, busy_o, done_o, cnt_o, pulses_o);
    end
    tick(); tick();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (pulse_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_after[%0d]: got p=%b b=%b, want 0 0", i, pulse_o, busy_o);
      end
    end
  endtask

  task automatic test_basic_train;
    logic ep, eb, ed;
    set_cfg(2, 3, 5, 2);
    start_i = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      tick();
      start_i = 1'b0;
      ep = ((e >= 2) && (e < 5)) || ((e >= 10) && (e < 13));
      eb = (e < 18);
      ed = (e == 18);
      checks++;
      if (pulse_o !== ep || busy_o !== eb || done_o !== ed) begin
        errors++;
        $display("FAIL basic_edge%0d: got p=%b b=%b d=%b, want p=%b b=%b d=%b",
                 e, pulse_o, busy_o, done_o, ep, eb, ed);
      end
      if (e == 1 || e == 2 || e == 4 || e == 9) begin
        checks++;
        if (cnt_o !== ((e == 1) ? 16'd1 : (e == 2) ? 16'd0 : (e == 4) ? 16'd2 : 16'd4)) begin
          errors++;
          $display("FAIL basic_cnt_edge%0d: got %0d", e, cnt_o);
        end
      end
      if (e == 4 || e == 5 || e == 13 || e == 21) begin
        checks++;
        if (pulses_o !== ((e == 4) ? 8'd0 : (e == 5) ? 8'd1 : 8'd2)) begin
          errors++;
          $display("FAIL basic_pulses_edge%0d: got %0d", e, pulses_o);
        end
      end
    end
  endtask

  task automatic test_zero_fields;
    logic ep, eb, ed;
    set_cfg(0, 0, 0, 3);
    start_i = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      start_i = 1'b0;
      ep = (e < 6) && (e % 2 == 0);
      eb = (e < 6);
      ed = (e == 6);
      checks++;
      if (pulse_o !== ep || busy_o !== eb || done_o !== ed) begin
        errors++;
        $display("FAIL zero_edge%0d: got p=%b b=%b d=%b, want p=%b b=%b d=%b",
                 e, pulse_o, busy_o, done_o, ep, eb, ed);
      end
    end
    checks++;
    if (pulses_o !== 8'd3) begin
      errors++;
      $display("FAIL zero_pulses: got %0d, want 3", pulses_o);
    end
  endtask

  task automatic test_continuous_abort;
    logic [7:0] exp_p;
    set_cfg(0, 1, 1, 0);
    start_i = 1'b1;
    for (int e = 0; e <= 600; e++) begin
      tick();
      start_i = 1'b0;
      exp_p = 8'(((e + 1) / 2) % 256);
      checks++;
      if (pulse_o !== (e % 2 == 0) || busy_o !== 1'b1 || done_o !== 1'b0 || pulses_o !== exp_p) begin
        errors++;
        $display("FAIL cont_edge%0d: got p=%b b=%b d=%b pulses=%0d, want p=%b b=1 d=0 pulses=%0d",
                 e, pulse_o, busy_o, done_o, pulses_o, (e % 2 == 0), exp_p);
      end
    end
    abort_i = 1'b1;               // in HIGH with 44 pulses done
    tick();
    abort_i = 1'b0;
    checks++;
    if (pulse_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || cnt_o !== 16'd0 || pulses_o !== 8'd44) begin
      errors++;
      $display("FAIL abort: got p=%b b=%b d=%b cnt=%0d pulses=%0d, want 0 0 0 0 44",
               pulse_o, busy_o, done_o, cnt_o, pulses_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || pulses_o !== 8'd44) begin
      errors++;
      $display("FAIL abort_hold: got b=%b d=%b pulses=%0d, want 0 0 44", busy_o, done_o, pulses_o);
    end
  endtask

  task automatic test_collisions;
    logic ep, eb, ed;
    set_cfg(1, 2, 2, 1);
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || pulse_o !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: got b=%b p=%b, want 0 0", busy_o, pulse_o);
    end
    // start_i stays high for the whole run; config changes at edge 2
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 2) set_cfg(7, 9, 9, 5);
      if (e == 5) start_i = 1'b0;
      ep = (e >= 1) && (e < 3);
      eb = (e < 5);
      ed = (e == 5);
      checks++;
      if (pulse_o !== ep || busy_o !== eb || done_o !== ed) begin
        errors++;
        $display("FAIL collide_edge%0d: got p=%b b=%b d=%b, want p=%b b=%b d=%b",
                 e, pulse_o, busy_o, done_o, ep, eb, ed);
      end
    end
  endtask

  task automatic test_restart;
    logic ep, eb, ed;
    set_cfg(0, 1, 1, 1);
    start_i = 1'b1;
    for (int e = 0; e <= 2; e++) tick();   // done at edge 2, start ignored there
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || pulses_o !== 8'd1) begin
      errors++;
      $display("FAIL restart_first_done: got d=%b b=%b pulses=%0d, want 1 0 1", done_o, busy_o, pulses_o);
    end
    set_cfg(2, 2, 1, 1);
    for (int j = 0; j <= 7; j++) begin
      tick();
      start_i = 1'b0;
      ep = (j >= 2) && (j < 4);
      eb = (j < 5);
      ed = (j == 5);
      checks++;
      if (pulse_o !== ep || busy_o !== eb || done_o !== ed || pulses_o !== ((j >= 4) ? 8'd1 : 8'd0)) begin
        errors++;
        $display("FAIL restart_edge%0d: got p=%b b=%b d=%b pulses=%0d, want p=%b b=%b d=%b pulses=%0d",
                 j, pulse_o, busy_o, done_o, pulses_o, ep, eb, ed, (j >= 4) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_train();
    tick();
    test_zero_fields();
    tick();
    test_continuous_abort();
    tick();
    test_collisions();
    tick();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
